// File: rtl/sm_to_twos_serial_if.sv
// Handshake bundle for the serial sign-magnitude to two's complement unit.
// master drives start/inp; slave returns out/busy/valid.
interface sm_to_twos_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] inp;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             valid;

  modport master (
    output start,
    output inp,
    input  out,
    input  busy,
    input  valid
  );

  modport slave (
    input  start,
    input  inp,
    output out,
    output busy,
    output valid
  );
endinterface

// File: rtl/sm_to_twos_serial.sv
// Bit-serial sign-magnitude to two's complement converter, LSB first.
// Ports: clk, reset (sync, active-high), bus (start/inp in; out/busy/valid out).
module sm_to_twos_serial #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sm_to_twos_serial_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             seen_q, seen_d;
  logic             bit_in;
  logic             res_bit;

  // Operand is held magnitude-only with a zero top bit, so the bit
  // processed at index WIDTH-1 is always 0 without a special case.
  assign bit_in  = op_q[0];
  assign res_bit = (sign_q & seen_q) ? ~bit_in : bit_in;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    seen_d  = seen_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          op_d    = {1'b0, bus.inp[WIDTH-2:0]};
          sign_d  = bus.inp[WIDTH-1];
          cnt_d   = '0;
          seen_d  = 1'b0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d  = {res_bit, res_q[WIDTH-1:1]};
        op_d   = op_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        seen_d = seen_q | bit_in;
        if (cnt_q == LAST) begin
          out_d   = res_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      seen_q  <= seen_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = (state_q == DONE);
  assign bus.busy  = (state_q == SHIFT);
endmodule

// File: tb/tb_sm_to_twos_serial.sv
// Self-checking bench for sm_to_twos_serial (WIDTH=4).
// Timing-level model plus directed literal checks.
module tb_sm_to_twos_serial;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sm_to_twos_serial_if #(.WIDTH(W)) bus();

  sm_to_twos_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] conv(input logic [W-1:0] v);
    int mag;
    mag = int'(v[W-2:0]);
    if (v[W-1]) return W'((2**W - mag) % (2**W));
    return W'(mag);
  endfunction

  // Model: an accepted start at edge a means busy after edges a..a+W-1,
  // result and valid after edge a+W; starts at edges a+1..a+W are dropped.
  int           edge_n = 0;
  bit           have = 0;
  int           acc_e = 0;
  logic [W-1:0] acc_val = '0;
  logic [W-1:0] eo = '0;
  bit           ev = 0;
  bit           eb = 0;

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        have = 0;
        eo   = '0;
        ev   = 0;
        eb   = 0;
      end else begin
        if (have && edge_n == acc_e + W) eo = acc_val;
        if (bus.start && !(have && edge_n > acc_e && edge_n <= acc_e + W)) begin
          have    = 1;
          acc_e   = edge_n;
          acc_val = conv(bus.inp);
        end
        eb = have && edge_n >= acc_e && edge_n < acc_e + W;
        ev = have && edge_n == acc_e + W;
      end
    end
  end

  logic prev_valid = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (edge_n > 0) begin
        chk("m_valid", bus.valid, ev);
        chk("m_busy", bus.busy, eb);
        chk("m_out", bus.out, eo);
        chk("valid_run", prev_valid & bus.valid, 0);
        prev_valid = bus.valid;
      end
    end
  end

  task automatic go(input logic [W-1:0] v);
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.inp   = v;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    bus.inp   = W'($urandom);
  endtask

  task automatic wait_valid(input string nm, input logic [W-1:0] lit,
                            output int bcnt);
    int n;
    n    = 0;
    bcnt = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.valid) break;
      n++;
    end
    chk({nm, "_seen"}, bus.valid, 1);
    chk(nm, bus.out, lit);
  endtask

  initial begin
    int b;
    int n;
    int t1, t2;
    logic [W-1:0] o1, o2;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.inp   = '0;

    chk("pin_m1", conv(4'b1001), 4'b1111);
    chk("pin_m7", conv(4'b1111), 4'b1001);
    chk("pin_nz", conv(4'b1000), 4'b0000);
    chk("pin_p3", conv(4'b0011), 4'b0011);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", bus.out, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    go(4'b1001);
    wait_valid("neg1", 4'b1111, b);
    chk("busy_cycles", b, 4);
    go(4'b0011);
    wait_valid("pos3", 4'b0011, b);
    go(4'b1111);
    wait_valid("neg7", 4'b1001, b);
    go(4'b1000);
    wait_valid("negzero", 4'b0000, b);

    // Back-to-back with start held high.
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.inp   = 4'b1010;
    @(posedge clk);
    #2;
    bus.inp = 4'b0101;
    n = 0;
    while (n < 20 && !bus.valid) begin
      @(negedge clk);
      n++;
    end
    t1 = edge_n;
    o1 = bus.out;
    @(negedge clk);
    n = 0;
    while (n < 20 && !bus.valid) begin
      @(negedge clk);
      n++;
    end
    t2 = edge_n;
    o2 = bus.out;
    bus.start = 1'b0;
    chk("b2b_v2", bus.valid, 1);
    chk("b2b_gap", t2 - t1, 5);
    chk("b2b_o1", o1, 4'b1110);
    chk("b2b_o2", o2, 4'b0101);
    repeat (3) @(posedge clk);

    // Start during SHIFT is dropped.
    go(4'b1101);
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.inp   = 4'b0111;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    wait_valid("ign_start", 4'b1011, b);
    repeat (8) @(negedge clk);
    chk("ign_idle", bus.busy, 0);

    // Reset in the second SHIFT cycle.
    go(4'b0110);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", bus.out, 0);
    chk("mid_rst_valid", bus.valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.valid) n++;
    end
    chk("mid_rst_nopulse", n, 0);

    for (int v = 0; v < 16; v++) begin
      go(W'(v));
      wait_valid("sweep", conv(W'(v)), b);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
